btn_cmd_ctrl: RTL and testbench
===============================

// Module: btn_cmd_ctrl
// PURPOSE
//  Front-end controller for N_BTN raw pushbuttons. Per channel: 2-flop synchronise, debounce, press detect.
//  Queues one pending press per channel and round-robin arbitrates them onto a single valid/ready
//  command stream that feeds the lab's top-level control FSM. Flags presses lost to a full pending slot.
// PARAMETERS
//  N_BTN           4   number of button channels (>=2)
//  DEBOUNCE_CYCLES 16  cycles synced level must differ from stable level before it is accepted (>=2)
//  ID_W            $clog2(N_BTN)  width of cmd_id (localparam, derived)
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, asynchronous, active-low
//  btn_raw      in   N_BTN  asynchronous raw button levels, 1 = pressed
//  btn_level    out  N_BTN  debounced stable level per channel
//  cmd_valid    out  1      command offered
//  cmd_id       out  ID_W   channel index of offered command
//  cmd_ready    in   1      consumer accepts command this cycle
//  cmd_overrun  out  1      sticky: press lost while that channel already pending
//  overrun_clr  in   1      synchronous clear of cmd_overrun
// BEHAVIOUR
//  Reset (rst=0, async): all flops 0 -> btn_level=0, cmd_valid=0, cmd_id=0, cmd_overrun=0, pending=0,
//    state=IDLE; last_grant=N_BTN-1 (channel 0 has first priority). Reset mid-offer drops the command.
//  Sync: s1<=btn_raw[i]; s2<=s1. s2 is the synced level; nothing downstream uses s1.
//  Debounce per channel: cnt increments each cycle s2!=stable; cnt<=0 when s2==stable.
//    When s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
//    Latency: raw value first sampled into s1 at edge k -> btn_level changes at edge k+DEBOUNCE_CYCLES+1,
//    provided raw held. Any glitch back to the stable level restarts cnt from 0.
//  Press event: one-cycle pulse when stable goes 0->1. Release produces no event.
//  Pending: press sets pending[i]. Press while pending[i]=1 -> cmd_overrun<=1; pending unchanged.
//    Press on the channel being granted in the same cycle: pending stays 1, no overrun.
//    overrun_clr and a new overrun in the same cycle: set wins.
//  FSM states IDLE, OFFER:
//    IDLE: if |pending -> pick first set bit scanning last_grant+1, +2, ... modulo N_BTN (wraps);
//          cmd_id<=pick, pending[pick]<=0, cmd_valid<=1, ->OFFER. Otherwise stay IDLE, cmd_valid=0.
//    OFFER: cmd_valid=1, cmd_id held stable until cmd_ready=1. On cmd_valid&cmd_ready:
//          last_grant<=cmd_id, cmd_valid<=0, ->IDLE.
//  Throughput: max 1 command per 2 cycles. The bubble cycle after every handshake is required.
//  Press on channel cmd_id during OFFER: sets pending[cmd_id] normally. No overrun, because that slot was already cleared.
//  First cmd_valid: press pulse at edge p -> pending at p -> cmd_valid at edge p+1.
//  cmd_ready while cmd_valid=0: ignored.
// STRUCTURE
//  Package btn_ctrl_pkg: typedef enum logic {IDLE, OFFER} arb_state_t; and a function rr_pick(pending,
//    last_grant) returning the round-robin index. No other shared constants.
//  Sub-module btn_debounce (params DEBOUNCE_CYCLES): clk, rst, raw -> level, press_pulse. Contains the sync,
//    the counter and the edge detect. btn_cmd_ctrl generate-instantiates N_BTN copies and adds the pending
//    register, the arbiter FSM and the overrun flag.
// TESTING (bench N_BTN=4, DEBOUNCE_CYCLES=4)
//  1 reset: assert rst=0 mid-run with pending=4'b1011 and cmd_valid=1 -> all outputs 0 immediately, no cmd after release.
//  2 debounce: raw[1] 0->1 sampled at edge k, held -> btn_level[1]=1 at edge k+5. cmd_valid=1, cmd_id=1 at k+7.
//    Raw pulses of 3 cycles produce no level change.
//  3 round-robin: press ch0,2,3 same cycle, cmd_ready=1 -> cmd_id sequence 0,2,3, cmd_valid low between.
//    Then ch3,0 -> 0,3 (wrap from last_grant=3).
//  4 backpressure: cmd_ready=0 for 10 cycles -> cmd_valid and cmd_id stable throughout. Consumed on first ready.
//  5 overrun: press ch2 twice while held off by ready=0 -> second press sets cmd_overrun=1, only one ch2 cmd.
//    overrun_clr with a simultaneous new overrun -> stays 1.
//  6 re-press during OFFER of ch1 -> ch1 offered again after the bubble. cmd_overrun remains 0.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared types and helpers for the pushbutton command controller.
package btn_ctrl_pkg;

    // Arbiter states: IDLE looks for a pending press, OFFER holds a command until accepted.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    // Round-robin pick: first set bit of pending scanning last_grant+1, +2, ... modulo n_btn.
    // Returns last_grant when nothing is pending (callers only use the result when |pending).
    function automatic int unsigned rr_pick(input logic [31:0]  pending,
                                            input int unsigned  last_grant,
                                            input int unsigned  n_btn);
        int unsigned idx;
        logic        found;
        rr_pick = last_grant;
        found   = 1'b0;
        for (int unsigned d = 1; d <= 32; d++) begin
            if (!found && (d <= n_btn)) begin
                idx = last_grant + d;
                if (idx >= n_btn) begin
                    idx = idx - n_btn;
                end
                if (pending[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter and press (0->1) edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // The synced level has disagreed with the stable level long enough to be taken.
    assign w_accept = (r_s2 != r_stable) && (r_cnt == CNT_LAST);

    // Two-flop synchroniser; only r_s2 is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2 == r_stable) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-cycle pulse in the cycle after the stable level rises; releases are silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept & r_s2;
        end
    end

    assign level       = r_stable;
    assign press_pulse = r_press;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Pushbutton front end: per-channel debounce, one pending press per channel,
// round-robin arbitration onto a valid/ready command stream, sticky overrun flag.
//
// Handshake: cmd_valid/cmd_id are held stable while cmd_valid=1 and cmd_ready=0;
// a command transfers on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready is
// ignored while cmd_valid=0. After every transfer there is one idle cycle.
module btn_cmd_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter  int N_BTN           = 4,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int ID_W            = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_id,
    input  logic             cmd_ready,
    output logic             cmd_overrun,
    input  logic             overrun_clr
);

    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] w_clr;
    logic [ID_W-1:0]  r_cmd_id;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  w_pick;
    logic             r_overrun;
    logic             w_grant;
    logic             w_handshake;
    logic             w_ovr_set;
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn_raw[g]),
            .level      (btn_level[g]),
            .press_pulse(w_press[g])
        );
    end

    assign w_pick = ID_W'(rr_pick(32'(r_pending), 32'(r_last_grant), N_BTN));

    // Arbiter next state: grant from IDLE when anything is pending, release on handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_clr       = '0;
        w_handshake = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_grant     = 1'b1;
                    w_clr       = N_BTN'(1) << w_pick;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A press only overruns when its slot is still full after this cycle's grant.
    assign w_ovr_set = |(w_press & r_pending & ~w_clr);

    // Arbiter state, offered id and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cmd_id     <= '0;
            r_last_grant <= ID_W'(N_BTN - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_cmd_id <= w_pick;
            end
            if (w_handshake) begin
                r_last_grant <= r_cmd_id;
            end
        end
    end

    // Pending slots: granted slot clears, new presses set (a press on the granted slot keeps it set).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_press;
        end
    end

    // Sticky overrun flag; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign cmd_valid   = (r_state == OFFER);
    assign cmd_id      = r_cmd_id;
    assign cmd_overrun = r_overrun;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Bench for btn_cmd_ctrl with N_BTN=4, DEBOUNCE_CYCLES=4: directed scenarios followed by
// randomized button/ready traffic, all checked each cycle against a behavioural model.
module tb_btn_cmd_ctrl;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic         cmd_valid;
    logic [1:0]   cmd_id;
    logic         cmd_ready = 1'b0;
    logic         cmd_overrun;
    logic         overrun_clr = 1'b0;

    btn_cmd_ctrl #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .cmd_ready  (cmd_ready),
        .cmd_overrun(cmd_overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_pending;
    int           m_run [N];
    bit           m_valid;
    int           m_id;
    int           m_last;
    bit           m_ovr;

    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_pending = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_valid = 0; m_id = 0; m_last = N - 1; m_ovr = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        logic [N-1:0] clr = '0;
        logic [N-1:0] nxt_press = '0;
        bit           found = 0;
        int           c;
        if (!m_valid) begin
            for (int d = 1; d <= N; d++) begin
                c = (m_last + d) % N;
                if (!found && m_pending[c]) begin
                    found  = 1;
                    clr[c] = 1'b1;
                    m_id   = c;
                end
            end
            if (found) m_valid = 1;
        end else if (cmd_ready) begin
            m_last  = m_id;
            m_valid = 0;
        end
        if ((m_press & m_pending & ~clr) != '0) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        m_pending = (m_pending & ~clr) | m_press;
        for (int ch = 0; ch < N; ch++) begin
            if (m_s2[ch] != m_level[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == D) begin
                    m_level[ch]   = m_s2[ch];
                    m_run[ch]     = 0;
                    nxt_press[ch] = m_level[ch];
                end
            end else begin
                m_run[ch] = 0;
            end
        end
        m_press = nxt_press;
        m_s2    = m_s1;
        m_s1    = btn_raw;
    endtask

    task automatic check_all();
        chk("level", 32'(btn_level), 32'(m_level));
        chk("valid", 32'(cmd_valid), 32'(m_valid));
        chk("id", 32'(cmd_id), 32'(m_id));
        chk("overrun", 32'(cmd_overrun), 32'(m_ovr));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_id", 32'(cmd_id), 32'd0);
        chk("rst_overrun", 32'(cmd_overrun), 32'd0);
    endtask

    task automatic step();
        if (cmd_valid && cmd_ready) got_q.push_back(cmd_id);
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!cmd_valid && k < budget) begin
            step();
            k++;
        end
        chk("wait_valid", 32'(cmd_valid), 32'd1);
    endtask

    task automatic press_ch(input int ch);
        btn_raw[ch] = 1'b1;
        steps(8);
        btn_raw[ch] = 1'b0;
        steps(8);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    initial begin
        int e;
        int k;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        #3 rst = 1'b1;

        // Round-robin: ch0,2,3 together, then ch3,0 wrapping from last grant 3
        cmd_ready = 1'b1;
        got_q.delete();
        btn_raw = 4'b1101;
        steps(14);
        btn_raw = 4'b0000;
        steps(10);
        exp_q = '{2'd0, 2'd2, 2'd3};
        chk_seq("rr_first");
        got_q.delete();
        btn_raw = 4'b1001;
        steps(14);
        btn_raw = 4'b0000;
        steps(10);
        exp_q = '{2'd0, 2'd3};
        chk_seq("rr_wrap");

        // Debounce latency and backpressure on ch1
        cmd_ready = 1'b0;
        got_q.delete();
        btn_raw[1] = 1'b1;
        step();
        e = 0;
        while (!btn_level[1] && e < 20) begin
            step();
            e++;
        end
        chk("level_latency", 32'(e), 32'd5);
        while (!cmd_valid && e < 20) begin
            step();
            e++;
        end
        chk("cmd_latency", 32'(e), 32'd7);
        chk("cmd_id_ch1", 32'(cmd_id), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_id", 32'(cmd_id), 32'd1);
        end
        cmd_ready = 1'b1;
        step();
        chk("bubble", 32'(cmd_valid), 32'd0);
        exp_q = '{2'd1};
        chk_seq("backpressure");
        btn_raw[1] = 1'b0;
        steps(10);

        // Short glitch never reaches the stable level
        btn_raw[2] = 1'b1;
        steps(3);
        btn_raw[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("glitch", 32'(btn_level[2]), 32'd0);
        end

        // Overrun: ch0 held in offer, ch2 pressed twice, then clear vs. set race
        cmd_ready = 1'b0;
        got_q.delete();
        btn_raw[0] = 1'b1;
        wait_valid(20);
        chk("ovr_first_id", 32'(cmd_id), 32'd0);
        press_ch(2);
        chk("ovr_not_yet", 32'(cmd_overrun), 32'd0);
        press_ch(2);
        chk("ovr_set", 32'(cmd_overrun), 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clear", 32'(cmd_overrun), 32'd0);
        btn_raw[2] = 1'b1;
        k = 0;
        while (!m_press[2] && k < 20) begin
            step();
            k++;
        end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(cmd_overrun), 32'd1);
        steps(6);
        btn_raw = 4'b0000;
        steps(8);
        cmd_ready = 1'b1;
        steps(8);
        exp_q = '{2'd0, 2'd2};
        chk_seq("ovr_cmds");
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;

        // Re-press of ch1 while ch1 is being offered
        cmd_ready = 1'b0;
        got_q.delete();
        btn_raw[1] = 1'b1;
        wait_valid(20);
        btn_raw[1] = 1'b0;
        steps(8);
        btn_raw[1] = 1'b1;
        steps(8);
        chk("repress_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        steps(6);
        exp_q = '{2'd1, 2'd1};
        chk_seq("repress");
        chk("repress_no_ovr", 32'(cmd_overrun), 32'd0);
        btn_raw = 4'b0000;
        steps(10);

        // Asynchronous reset with ch2 offered and 1011 pending
        cmd_ready = 1'b0;
        got_q.delete();
        btn_raw = 4'b0100;
        wait_valid(20);
        btn_raw = 4'b1111;
        k = 0;
        while (m_pending != 4'b1011 && k < 20) begin
            step();
            k++;
        end
        chk("pre_reset_valid", 32'(cmd_valid), 32'd1);
        btn_raw = 4'b0000;
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        cmd_ready = 1'b1;
        steps(20);
        chk("no_cmd_after_reset", 32'(got_q.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[ch] = ~btn_raw[ch];
            end
            cmd_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
